vga_sync_gen: RTL

//  Upstream raster timing stage for main_logic: generates 640x480@60Hz VGA scan position and sync.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_sync_gen_if.sv | 23 ++
 rtl/pixel_tick_div.sv | 25 ++
 rtl/vga_sync_gen.sv | 81 ++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster timing types, default 640x480@60 timing and helpers
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL      = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL      = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    // Inclusive window test used for both sync pulses.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster position and sync bundle between timing stage and consumers
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic   en;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   p_tick;
    logic   frame_start;

    modport master (
        input  en,
        output pixel_x, pixel_y, video_on, hsync, vsync, p_tick, frame_start
    );

    modport slave (
        output en,
        input  pixel_x, pixel_y, video_on, hsync, vsync, p_tick, frame_start
    );
endinterface

// File: rtl/pixel_tick_div.sv
// rtl/pixel_tick_div.sv - system clock to pixel tick divider
module pixel_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    assign tick = en && (div_cnt == LAST);

    // Free-running 0..CLK_DIV-1 count that holds its phase while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters with registered sync and blanking qualifiers
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV   = 2,
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    vga_sync_gen_if.master vif
);
    localparam coord_t H_LAST   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   tick;
    coord_t x_q, y_q, x_nx, y_nx;
    logic   video_q, hsync_q, vsync_q, p_tick_q, frame_q;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (vif.en),
        .tick (tick)
    );

    // Position the raster moves to on the next tick; wraps explicitly at the totals.
    always_comb begin
        x_nx = x_q + 1'b1;
        y_nx = y_q;
        if (x_q == H_LAST) begin
            x_nx = '0;
            y_nx = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end
    end

    // Counters and qualifiers all load from the next position so they describe the same pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= H_LAST;
            y_q      <= V_LAST;
            video_q  <= 1'b0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            p_tick_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            p_tick_q <= tick;
            frame_q  <= tick && (x_nx == '0) && (y_nx == '0);
            if (tick) begin
                x_q     <= x_nx;
                y_q     <= y_nx;
                video_q <= (x_nx < H_VIS) && (y_nx < V_VIS);
                hsync_q <= in_window(x_nx, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
                vsync_q <= in_window(y_nx, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign vif.pixel_x     = x_q;
    assign vif.pixel_y     = y_q;
    assign vif.video_on    = video_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    // Pulses are suppressed while the stage is paused.
    assign vif.p_tick      = p_tick_q & vif.en;
    assign vif.frame_start = frame_q & vif.en;
endmodule
